// File: rtl/icache_direct_mapped_if.sv
// rtl/icache_direct_mapped_if.sv - fetch and ROM refill signal bundle for the direct-mapped icache
//
// Purpose: groups the IF-stage fetch handshake and the ROM refill port.
// Ports (slave = cache side):
//   fetch_en, pc, invalidate  : fetch request from the IF stage
//   instr, instr_ready        : instruction returned on a hit
//   mem_req, mem_addr         : word-read request towards the ROM
//   mem_rdata, mem_valid      : ROM read data and beat completion
interface icache_direct_mapped_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  invalidate;
    logic [31:0]           instr;
    logic                  instr_ready;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rdata;
    logic                  mem_valid;

    modport slave (
        input  fetch_en, pc, invalidate, mem_rdata, mem_valid,
        output instr, instr_ready, mem_req, mem_addr
    );

    modport master (
        output fetch_en, pc, invalidate, mem_rdata, mem_valid,
        input  instr, instr_ready, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped instruction cache with word-by-word line refill
//
// Purpose: serves IF-stage fetches combinationally on a hit; on a miss refills the
// whole line from the ROM one word per mem_req/mem_valid beat, then serves the fetch.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   bus         : icache_direct_mapped_if.slave (fetch handshake + ROM refill port)
//   hit_count   : fetches served as hits (wraps)
//   miss_count  : refills started (wraps)
module icache_direct_mapped #(
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_direct_mapped_if.slave bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int OFF        = $clog2(WORDS_PER_LINE);
    localparam int IDX        = $clog2(NUM_LINES);
    localparam int OFF_W      = (OFF > 0) ? OFF : 1;
    localparam int TAG_W      = ADDR_WIDTH - OFF - IDX - 2;
    localparam int LINE_BYTES = 4 * WORDS_PER_LINE;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state_q, state_d;
    logic [OFF_W-1:0]      beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    // Set when invalidate arrives while a beat is outstanding: the beat must
    // still complete on the bus, but its data is dropped and the refill ends.
    logic                  abort_q, abort_d;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [31:0]           data_q [NUM_LINES][WORDS_PER_LINE];
    logic [CNT_WIDTH-1:0]  hit_count_q, miss_count_q;

    logic [OFF_W-1:0] pc_word;
    logic [IDX-1:0]   pc_index, fill_index;
    logic [TAG_W-1:0] pc_tag, fill_tag;
    logic             hit, last_beat, fill_write;
    logic             hit_inc, miss_inc;
    logic [31:0]      instr;
    logic             instr_ready, mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;

    assign pc_word    = OFF_W'((bus.pc >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1));
    assign pc_index   = IDX'(bus.pc >> (OFF + 2));
    assign pc_tag     = TAG_W'(bus.pc >> (OFF + IDX + 2));
    assign fill_index = IDX'(base_q >> (OFF + 2));
    assign fill_tag   = TAG_W'(base_q >> (OFF + IDX + 2));

    assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign last_beat  = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
    // A beat lands in the array only if nobody has invalidated this refill.
    assign fill_write = (state_q == REFILL) && bus.mem_valid && !abort_q && !bus.invalidate;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        abort_d     = abort_q;
        instr_ready = 1'b0;
        instr       = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fetch_en && !bus.invalidate) begin
                    if (hit) begin
                        instr_ready = 1'b1;
                        instr       = data_q[pc_index][pc_word];
                        hit_inc     = 1'b1;
                    end else begin
                        state_d  = REFILL;
                        beat_d   = '0;
                        abort_d  = 1'b0;
                        base_d   = bus.pc & ~ADDR_WIDTH'(LINE_BYTES - 1);
                        miss_inc = 1'b1;
                    end
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = base_q + (ADDR_WIDTH'(beat_q) << 2);
                if (bus.mem_valid) begin
                    if (abort_q || bus.invalidate || last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end else if (bus.invalidate) begin
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            abort_q      <= 1'b0;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            abort_q <= abort_d;
            if (hit_inc) hit_count_q <= hit_count_q + CNT_WIDTH'(1);
            if (miss_inc) miss_count_q <= miss_count_q + CNT_WIDTH'(1);
            // invalidate beats a final beat in the same cycle
            if (bus.invalidate) begin
                valid_q <= '0;
            end else if (fill_write && last_beat) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_write) begin
            data_q[fill_index][beat_q] <= bus.mem_rdata;
            if (last_beat) tag_q[fill_index] <= fill_tag;
        end
    end

    assign bus.instr       = instr;
    assign bus.instr_ready = instr_ready;
    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign hit_count       = hit_count_q;
    assign miss_count      = miss_count_q;
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - scoreboard bench for icache_direct_mapped
module tb_icache_direct_mapped;
    localparam int AW  = 32;
    localparam int NL  = 4;
    localparam int WPL = 4;
    localparam int CW  = 32;
    localparam int LB  = 4 * WPL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_direct_mapped_if #(.ADDR_WIDTH(AW)) bus ();
    logic [CW-1:0] hit_count, miss_count;

    icache_direct_mapped #(
        .ADDR_WIDTH(AW), .NUM_LINES(NL), .WORDS_PER_LINE(WPL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: which line base address each cache slot holds.
    bit              m_valid [NL];
    logic [AW-1:0]   m_base  [NL];
    int unsigned     m_hits, m_misses;
    logic [31:0]     exp_instr_q[$];
    logic [AW-1:0]   exp_addr_q[$];

    function automatic logic [AW-1:0] base_of(logic [AW-1:0] a);
        return (a / LB) * LB;
    endfunction
    function automatic int slot_of(logic [AW-1:0] a);
        return int'((a / LB) % NL);
    endfunction
    function automatic bit model_hit(logic [AW-1:0] a);
        return m_valid[slot_of(a)] && (m_base[slot_of(a)] == base_of(a));
    endfunction
    task automatic model_fill(input logic [AW-1:0] a);
        for (int i = 0; i < WPL; i++) exp_addr_q.push_back(base_of(a) + AW'(4 * i));
        m_valid[slot_of(a)] = 1'b1;
        m_base[slot_of(a)]  = base_of(a);
    endtask
    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // Monitor: every served fetch must match the oldest expected instruction.
    always @(negedge clk) begin
        if (!rst && bus.instr_ready) begin
            if (exp_instr_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: pc %0h instr %0h, no fetch expected", bus.pc, bus.instr);
            end else begin
                check("instr", bus.instr, exp_instr_q.pop_front());
            end
        end
    end

    // ROM: word at A is A; each beat answered after lat_lo..lat_hi idle cycles.
    int lat_lo = 2, lat_hi = 2;
    int rom_wait = -1;
    int rom_beats = 0;
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_valid = 1'b0;
            if (rst || !bus.mem_req) begin
                rom_wait = -1;
            end else begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_mem_req: addr %0h, none expected", bus.mem_addr);
                end else begin
                    check("mem_addr", bus.mem_addr, exp_addr_q[0]);
                end
                if (rom_wait < 0) rom_wait = $urandom_range(lat_hi, lat_lo);
                if (rom_wait == 0) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_rdata = bus.mem_addr;
                    if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
                    rom_beats++;
                    rom_wait = -1;
                end else begin
                    rom_wait--;
                end
            end
        end
    end

    task automatic wait_served(output bit got, output int cycles);
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (bus.instr_ready) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("fetch_served", got, 1'b1);
        @(posedge clk);
        #1;
        bus.fetch_en = 1'b0;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a);
        bit h, got;
        int cyc;
        h = model_hit(a);
        if (!h) begin
            m_misses++;
            model_fill(a);
        end
        m_hits++;
        exp_instr_q.push_back(a & ~32'h3);
        bus.fetch_en = 1'b1;
        bus.pc = a;
        wait_served(got, cyc);
        if (h) check("hit_latency", cyc, 1);
        else   check("miss_not_immediate", cyc > 1, 1'b1);
    endtask

    task automatic do_redirect(input logic [AW-1:0] a, input logic [AW-1:0] b, input int k);
        bit got;
        int cyc;
        if (model_hit(a)) begin
            do_fetch(a);
            do_fetch(b);
        end else begin
            m_misses++;
            model_fill(a);
            bus.fetch_en = 1'b1;
            bus.pc = a;
            repeat (k) @(posedge clk);
            #1;
            bus.pc = b;
            if (!model_hit(b)) begin
                m_misses++;
                model_fill(b);
            end
            m_hits++;
            exp_instr_q.push_back(b & ~32'h3);
            wait_served(got, cyc);
        end
    endtask

    task automatic do_inval_idle(input logic [AW-1:0] a);
        bus.fetch_en = 1'b1;
        bus.pc = a;
        bus.invalidate = 1'b1;
        @(negedge clk);
        check("inval_ready_low", bus.instr_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.invalidate = 1'b0;
        bus.fetch_en = 1'b0;
        model_clear();
    endtask

    task automatic do_inval_refill(input logic [AW-1:0] a, input int k);
        int start, n;
        do_inval_idle(a);
        m_misses++;
        for (int i = 0; i <= k; i++) exp_addr_q.push_back(base_of(a) + AW'(4 * i));
        bus.fetch_en = 1'b1;
        bus.pc = a;
        start = rom_beats;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rom_beats - start != k && n < 100);
        check("beats_before_inval", rom_beats - start, k);
        @(posedge clk);
        #1;
        bus.invalidate = 1'b1;
        bus.fetch_en = 1'b0;
        @(posedge clk);
        #1;
        bus.invalidate = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.mem_req && n < 50);
        check("req_dropped", bus.mem_req, 1'b0);
        repeat (3) @(negedge clk);
        check("aborted_beats_left", exp_addr_q.size(), 0);
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic do_reset(input bit mid_refill);
        logic [AW-1:0] a;
        a = 32'h40;
        for (int i = 0; i < NL; i++) if (m_valid[i]) a = m_base[i];
        if (mid_refill) begin
            do_inval_idle(a);
            model_fill(a);
            bus.fetch_en = 1'b1;
            bus.pc = a;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
        end else begin
            bus.fetch_en = 1'b1;
            bus.pc = a;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.fetch_en = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        model_clear();
        m_hits = 0;
        m_misses = 0;
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_ready", bus.instr_ready, 1'b0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        @(posedge clk);
        #1;
        do_fetch(a);
    endtask

    task automatic check_counters();
        @(negedge clk);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_pc();
        logic [AW-1:0] a;
        a = $urandom & 32'h000000FC;
        if ($urandom_range(3, 0) == 0) a = a | ($urandom & 32'hFFFFFF00);
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.fetch_en = 1'b0;
        bus.pc = '0;
        bus.invalidate = 1'b0;
        model_clear();
        m_hits = 0;
        m_misses = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", bus.instr_ready, 1'b0);
        check("reset_instr", bus.instr, 0);
        check("reset_mem_req", bus.mem_req, 1'b0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_hits", hit_count, 0);
        check("reset_misses", miss_count, 0);
        @(posedge clk);
        #1;

        do_fetch(32'h40);
        check_counters();
        do_fetch(32'h44);
        do_fetch(32'h48);
        do_fetch(32'h4C);
        check_counters();
        do_fetch(32'h80);
        do_fetch(32'h40);
        check_counters();
        do_inval_idle(32'h40);
        do_redirect(32'h40, 32'h10, 2);
        check_counters();
        do_inval_refill(32'h40, 2);
        do_fetch(32'h40);
        check_counters();
        do_reset(1'b1);
        check_counters();
        do_reset(1'b0);
        check_counters();

        lat_lo = 0;
        lat_hi = 2;
        for (int op = 0; op < 300; op++) begin
            int r;
            r = $urandom_range(31, 0);
            if (r < 22)       do_fetch(rand_pc());
            else if (r < 26)  do_redirect(rand_pc(), rand_pc(), $urandom_range(3, 1));
            else if (r < 28)  do_inval_idle(rand_pc());
            else if (r < 31)  do_inval_refill(rand_pc(), $urandom_range(3, 1));
            else              do_reset($urandom_range(1, 0) == 1);
            check_counters();
        end

        repeat (5) @(negedge clk);
        check("leftover_instr", exp_instr_q.size(), 0);
        check("leftover_addr", exp_addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
